// File: rtl/mux4n_reg.sv
// Registered 4:1 word multiplexer with a valid qualifier and a select echo.
// One-cycle latency, one word per cycle, and no combinational input-to-output path.
module mux4n_reg #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [1:0]       out_sel
);

    // Valid semantics: in_valid is always accepted (there is no ready signal).
    // Each sampled in_valid yields out_valid high for exactly the following cycle.
    // out and out_sel hold their values until the next sampled in_valid.

    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] r_out;
    logic             r_valid;
    logic [1:0]       r_sel;

    // Only the addressed word reaches w_sel_data, so X on an unselected input cannot leak.
    always_comb begin
        w_sel_data = d0;
        case (s)
            2'b00: w_sel_data = d0;
            2'b01: w_sel_data = d1;
            2'b10: w_sel_data = d2;
            2'b11: w_sel_data = d3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_sel   <= 2'b00;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_out <= w_sel_data;
                r_sel <= s;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign out_sel   = r_sel;

endmodule

// File: tb/tb_mux4n_reg.sv
// Directed bench for mux4n_reg: covers reset, the select sweep, hold, latency,
// X isolation, mid-stream reset, and an 8-bit instance.
module tb_mux4n_reg;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] d0, d1, d2, d3;
    logic [1:0] s;
    logic [4:0] out;
    logic       out_valid;
    logic [1:0] out_sel;

    logic       in_valid8;
    logic [7:0] e0, e1, e2, e3;
    logic [1:0] s8;
    logic [7:0] out8;
    logic       out_valid8;
    logic [1:0] out_sel8;

    int n_checks;
    int n_pass;

    mux4n_reg #(.WIDTH(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .s(s),
        .out(out), .out_valid(out_valid), .out_sel(out_sel)
    );

    mux4n_reg #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8),
        .d0(e0), .d1(e1), .d2(e2), .d3(e3), .s(s8),
        .out(out8), .out_valid(out_valid8), .out_sel(out_sel8)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0; s = 2'b00;
        in_valid8 = 1'b0;
        e0 = '0; e1 = '0; e2 = '0; e3 = '0; s8 = 2'b00;

        tick();
        tick();
        chk("rst_out",   64'(out),       64'h0);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_sel",   64'(out_sel),   64'h0);
        rst_n = 1'b1;
        tick();
        chk("idle_valid", 64'(out_valid), 64'h0);

        // Select sweep, back-to-back
        d0 = 5'b00001; d1 = 5'b00010; d2 = 5'b00100; d3 = 5'b01000;
        in_valid = 1'b1;
        s = 2'b00; tick();
        chk("sweep0_out", 64'(out), 64'h01); chk("sweep0_sel", 64'(out_sel), 64'h0); chk("sweep0_v", 64'(out_valid), 64'h1);
        s = 2'b01; tick();
        chk("sweep1_out", 64'(out), 64'h02); chk("sweep1_sel", 64'(out_sel), 64'h1); chk("sweep1_v", 64'(out_valid), 64'h1);
        s = 2'b10; tick();
        chk("sweep2_out", 64'(out), 64'h04); chk("sweep2_sel", 64'(out_sel), 64'h2); chk("sweep2_v", 64'(out_valid), 64'h1);
        s = 2'b11; tick();
        chk("sweep3_out", 64'(out), 64'h08); chk("sweep3_sel", 64'(out_sel), 64'h3); chk("sweep3_v", 64'(out_valid), 64'h1);

        // Hold: capture s=10, then drop in_valid and disturb inputs
        s = 2'b10; tick();
        chk("hold_cap_out", 64'(out), 64'h04);
        in_valid = 1'b0; s = 2'b11; d2 = 5'b11111;
        tick();
        chk("hold_out",   64'(out),       64'h04);
        chk("hold_sel",   64'(out_sel),   64'h2);
        chk("hold_valid", 64'(out_valid), 64'h0);
        s = 2'b01; d1 = 5'b10001; tick();
        chk("hold2_out", 64'(out), 64'h04);
        chk("hold2_sel", 64'(out_sel), 64'h2);
        d2 = 5'b00100; d1 = 5'b00010;

        // X on an unselected input
        d1 = 'x; d0 = 5'b10101; s = 2'b00; in_valid = 1'b1;
        tick();
        chk("xiso_out", 64'(out), 64'h15);
        chk("xiso_sel", 64'(out_sel), 64'h0);
        d1 = 5'b00010; d0 = 5'b00001;

        // Latency: capture d0, then switch to s=11 and observe before and after the edge
        tick();
        chk("lat_base", 64'(out), 64'h01);
        s = 2'b11;
        #2;
        chk("lat_same_cycle", 64'(out), 64'h01);
        tick();
        chk("lat_next_edge", 64'(out), 64'h08);
        chk("lat_sel", 64'(out_sel), 64'h3);

        // Mid-cycle asynchronous reset with a capture in flight
        s = 2'b01;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out",   64'(out),       64'h0);
        chk("arst_valid", 64'(out_valid), 64'h0);
        chk("arst_sel",   64'(out_sel),   64'h0);
        tick();
        chk("arst_hold_out", 64'(out), 64'h0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_out",   64'(out),       64'h0);
        chk("post_rst_valid", 64'(out_valid), 64'h0);
        in_valid = 1'b1; s = 2'b01;
        tick();
        chk("post_rst_cap", 64'(out), 64'h02);
        chk("post_rst_sel", 64'(out_sel), 64'h1);
        in_valid = 1'b0;

        // 8-bit instance
        e0 = 8'h3C; e1 = 8'h11; e2 = 8'h77; e3 = 8'hA5;
        in_valid8 = 1'b1; s8 = 2'b11;
        tick();
        chk("w8_out3", 64'(out8), 64'hA5);
        chk("w8_sel3", 64'(out_sel8), 64'h3);
        chk("w8_v",    64'(out_valid8), 64'h1);
        s8 = 2'b00;
        tick();
        chk("w8_out0", 64'(out8), 64'h3C);
        in_valid8 = 1'b0; s8 = 2'b10;
        tick();
        chk("w8_hold", 64'(out8), 64'h3C);
        chk("w8_v0",   64'(out_valid8), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux4n_reg.md
Name: mux4n_reg

Overview:
- Registered 4:1 multiplexer of WIDTH-bit data words.
- A 2-bit select picks one of four input words, which is captured into an output register on the rising clock edge.
- Used as a pipelined data-path selector wherever a one-cycle, glitch-free, registered mux output is required.
- Carries a valid qualifier and an echo of the select used, so downstream logic can track which source produced each word.

Parameters:
- WIDTH, 5, bit width of each data input and of the data output (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  when 1, the current d0..d3/s are sampled this cycle.
- d0  input  WIDTH  data word selected when s = 2'b00.
- d1  input  WIDTH  data word selected when s = 2'b01.
- d2  input  WIDTH  data word selected when s = 2'b10.
- d3  input  WIDTH  data word selected when s = 2'b11.
- s  input  2  select.
- out  output  WIDTH  registered selected word.
- out_valid  output  1  1 for exactly the cycle after each sampled in_valid.
- out_sel  output  2  registered copy of s that produced the current out.

Behaviour:
- Reset:
  - rst_n low asynchronously forces out = 0, out_valid = 0, out_sel = 2'b00, independent of clk.
  - Outputs stay at these values while rst_n is low.
  - Release is sampled on the next rising clk edge; the first capture is possible on the first rising edge with rst_n high.
- Selection mapping (combinational, before the register): s = 00 -> d0, 01 -> d1, 10 -> d2, 11 -> d3. The mapping is full; there are no illegal codes.
- Capture: on a rising clk with rst_n high and in_valid = 1:
  - out <= selected word;
  - out_sel <= s;
  - out_valid <= 1.
- Hold: on a rising clk with in_valid = 0:
  - out and out_sel hold their previous values;
  - out_valid <= 0.
- Latency: exactly 1 clock from the sampling edge to the out update. Throughput is one word per cycle; back-to-back in_valid is allowed with no bubbles.
- Changes on d0..d3 or s while in_valid = 0 have no effect on outputs.
- Outputs change only on a rising clk edge or on assertion of rst_n. There is no combinational path from inputs to outputs.
- X/Z on an unselected input must not propagate to out.
- Reset mid-stream: a capture in flight is discarded. After release, out = 0 until the next valid capture.
- No handshake back-pressure: there is no ready signal, and the block always accepts in_valid.

Test Plan:
- Reset: drive rst_n = 0 mid-cycle with out holding 5'b01000 -> out = 5'b00000, out_valid = 0, out_sel = 00 immediately, without waiting for a clk edge.
- Select sweep: set d0 = 00001, d1 = 00010, d2 = 00100, d3 = 01000 with in_valid = 1, then step s through 00, 01, 10, 11 on consecutive cycles. Each following cycle must show out = 00001, 00010, 00100, 01000 respectively, out_sel matching s, and out_valid = 1 continuously.
- Hold: after capturing s = 10 (out = 00100), drop in_valid and change s to 11 and d2 to 11111 -> out stays 00100, out_sel stays 10, out_valid = 0 from the next cycle.
- Latency: change s from 00 to 11 with in_valid = 1 -> out is still 00001 in the same cycle and becomes 01000 after exactly one rising edge.
- Unselected-X isolation: d1 = X, s = 00, d0 = 10101 -> out = 10101 with no X.
- Width parameter: instantiate with WIDTH = 8 and d3 = 8'hA5, s = 11 -> out = 8'hA5.
